fetch_decode_buffer: RTL and testbench
======================================

// Module: fetch_decode_buffer
// PURPOSE
//  Elastic IF/ID buffer for the segmented core: a small FIFO of {inst, pc} pairs
//  between the fetch stage (producer) and the decode stage (consumer).
//  - Decouples fetch from decode stalls with valid/ready handshakes.
//  - Discards in-flight wrong-path instructions on a taken branch/jump (flush).
//  - Presents a NOP bubble to decode when it holds nothing.
// PARAMETERS
//  XLEN      32              data/address width
//  DEPTH     2               entries; power of two, >= 2
//  NOP_INST  32'h0000_0013   bubble instruction (addi x0,x0,0) shown when empty
// PORTS
//  clk         in   1     rising-edge clock
//  rst         in   1     synchronous reset, active high
//  fe_inst     in   XLEN  instruction from fetch
//  fe_pc       in   XLEN  PC of fe_inst
//  fe_valid    in   1     fetch offers fe_inst/fe_pc this cycle
//  fe_ready    out  1     buffer accepts this cycle (gates PC update in fetch)
//  flush       in   1     redirect taken (NextPCSrc=1); drop all contents
//  de_inst     out  XLEN  head instruction, NOP_INST when empty
//  de_pc       out  XLEN  head PC, 0 when empty
//  de_pc_plus4 out  XLEN  de_pc + 4, modulo 2^XLEN
//  de_valid    out  1     head entry is valid
//  de_ready    in   1     decode consumes head this cycle
//  count       out  clog2(DEPTH)+1  occupied entries, 0..DEPTH
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//  - count=0, rd_ptr=wr_ptr=0, de_valid=0, de_inst=NOP_INST, de_pc=0,
//    fe_ready=1 from the following cycle; storage contents are don't-care.
//  Handshakes
//  - push = fe_valid & fe_ready & !flush
//  - pop  = de_valid & de_ready & !flush
//  - fe_ready = (count < DEPTH); driven from registered state only.
//    No combinational path from de_ready to fe_ready; no pass-through when full.
//  Data path
//  - de_* is driven combinationally from the head entry (mem[rd_ptr]).
//  - de_valid = (count != 0).
//  - A pushed entry reaches de_* at the earliest one cycle after its push edge.
//    The block never bypasses input to output in the same cycle.
//  - Entries are delivered in push order, exactly once, unmodified.
//  Pointers and count
//  - push: write mem[wr_ptr], wr_ptr+1 modulo DEPTH (wraps DEPTH-1 -> 0).
//  - pop : rd_ptr+1 modulo DEPTH.
//  - push&pop in the same cycle (only possible when 0<count<DEPTH): count
//    unchanged, both pointers advance.
//  - push only: count+1.  pop only: count-1.
//  - Pop while empty and push while full are impossible (gated by de_valid and
//    fe_ready). An assertion flags count>DEPTH.
//  Flush (priority: rst > flush > push/pop)
//  - Next cycle: count=0, rd_ptr=wr_ptr=0, de_valid=0.
//  - Any fe_valid data in the flush cycle is discarded (not pushed).
//  - fe_ready is 1 in the cycle after flush.
//  - A head presented during the flush cycle is not counted as consumed, even
//    if de_ready=1.
//  - Flush while already empty has no visible effect.
//  Reset mid-operation
//  - Identical to reset from idle; all entries are lost.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> count=0, de_valid=0, de_inst=32'h13,
//     de_pc=0, fe_ready=1.
//  2. Streaming: de_ready=1, push pc 0,4,8,C (inst=pc^32'hA5A5) on consecutive
//     cycles -> de_pc 0,4,8,C in order, one cycle behind pushes; count stays 1;
//     de_pc_plus4 = de_pc+4.
//  3. Full and stall: de_ready=0, push 3 beats -> 2 accepted, fe_ready=0 with
//     count=2, 3rd beat held by fetch. Raise de_ready -> beats drain in order,
//     3rd accepted once count<2.
//  4. Wrap: 10 pushes with alternating de_ready -> pointers wrap 1->0 repeatedly;
//     no loss, no duplication (scoreboard compare).
//  5. Flush: count=2, flush=1 with fe_valid=1 pc=0x40 -> next cycle count=0,
//     de_valid=0, 0x40 not delivered. Push 0x80 -> de_pc=0x80 one cycle later.
//  6. Boundaries: de_pc=0xFFFF_FFFC -> de_pc_plus4=0. Flush and rst in the same
//     cycle -> reset values. Push&pop at count=1 -> count stays 1.

Source files
------------

// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: elastic IF/ID FIFO of {inst, pc} pairs with flush and NOP bubble when empty
module fetch_decode_buffer #(
  parameter int XLEN = 32,
  parameter int DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic clk,
  input  logic rst,
  input  logic [XLEN-1:0] fe_inst,
  input  logic [XLEN-1:0] fe_pc,
  input  logic fe_valid,
  output logic fe_ready,
  input  logic flush,
  output logic [XLEN-1:0] de_inst,
  output logic [XLEN-1:0] de_pc,
  output logic [XLEN-1:0] de_pc_plus4,
  output logic de_valid,
  input  logic de_ready,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [2*XLEN-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [2*XLEN-1:0] head;
  logic push, pop;
  always_comb begin
    fe_ready = count < CW'(DEPTH);
    de_valid = count != '0;
    push = fe_valid & fe_ready & ~flush;
    pop = de_valid & de_ready & ~flush;
    head = mem[rd_ptr];
    de_inst = de_valid ? head[2*XLEN-1:XLEN] : NOP_INST;
    de_pc = de_valid ? head[XLEN-1:0] : '0;
    de_pc_plus4 = de_pc + XLEN'(4);
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {fe_inst, fe_pc};
  always_ff @(posedge clk)
    if (!rst) assert (count <= CW'(DEPTH));
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// tb_fetch_decode_buffer: directed checks of the IF/ID buffer with hand-computed expectations
module tb_fetch_decode_buffer;
  logic clk = 0, rst = 1, fe_valid = 0, flush = 0, de_ready = 0;
  logic [31:0] fe_inst = 0, fe_pc = 0;
  logic fe_ready, de_valid;
  logic [31:0] de_inst, de_pc, de_pc_plus4;
  logic [1:0] count;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  fetch_decode_buffer dut (
    .clk(clk), .rst(rst), .fe_inst(fe_inst), .fe_pc(fe_pc), .fe_valid(fe_valid),
    .fe_ready(fe_ready), .flush(flush), .de_inst(de_inst), .de_pc(de_pc),
    .de_pc_plus4(de_pc_plus4), .de_valid(de_valid), .de_ready(de_ready), .count(count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic v, input logic [31:0] pc);
    fe_valid = v;
    fe_pc = pc;
    fe_inst = pc ^ 32'hA5A5;
  endtask
  initial begin
    int sent, got;
    step;
    step;
    rst = 0;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(de_valid), 0);
    check("rst_inst", de_inst, 32'h13);
    check("rst_pc", de_pc, 0);
    check("rst_ready", 32'(fe_ready), 1);
    check("rst_plus4", de_pc_plus4, 4);
    de_ready = 1;
    for (int i = 0; i < 4; i++) begin
      offer(1, 32'(4 * i));
      step;
      check("stream_pc", de_pc, 32'(4 * i));
      check("stream_inst", de_inst, 32'(4 * i) ^ 32'hA5A5);
      check("stream_count", 32'(count), 1);
      check("stream_plus4", de_pc_plus4, 32'(4 * i + 4));
    end
    offer(0, 0);
    step;
    check("stream_drain", 32'(count), 0);
    de_ready = 0;
    offer(1, 32'h100);
    step;
    check("full_c1", 32'(count), 1);
    offer(1, 32'h104);
    step;
    check("full_c2", 32'(count), 2);
    check("full_ready", 32'(fe_ready), 0);
    offer(1, 32'h108);
    step;
    check("full_hold", 32'(count), 2);
    check("full_head", de_pc, 32'h100);
    de_ready = 1;
    step;
    check("drain_c1", 32'(count), 1);
    check("drain_pc1", de_pc, 32'h104);
    step;
    check("drain_c2", 32'(count), 1);
    check("drain_pc2", de_pc, 32'h108);
    offer(0, 0);
    step;
    check("drain_empty", 32'(count), 0);
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
      offer(sent < 10, 32'h200 + 32'(4 * sent));
      de_ready = cyc[0];
      if (de_valid && de_ready) begin
        check("wrap_pc", de_pc, 32'h200 + 32'(4 * got));
        check("wrap_inst", de_inst, (32'h200 + 32'(4 * got)) ^ 32'hA5A5);
        got++;
      end
      if (fe_valid && fe_ready) sent++;
      step;
    end
    check("wrap_total", 32'(got), 10);
    offer(0, 0);
    check("wrap_empty", 32'(count), 0);
    de_ready = 0;
    offer(1, 32'h300);
    step;
    offer(1, 32'h304);
    step;
    check("flush_pre", 32'(count), 2);
    offer(1, 32'h40);
    flush = 1;
    step;
    flush = 0;
    offer(0, 0);
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(de_valid), 0);
    check("flush_inst", de_inst, 32'h13);
    check("flush_ready", 32'(fe_ready), 1);
    step;
    check("flush_no40", 32'(count), 0);
    offer(1, 32'h80);
    step;
    offer(0, 0);
    check("flush_push80", de_pc, 32'h80);
    de_ready = 1;
    offer(1, 32'h44);
    flush = 1;
    step;
    flush = 0;
    offer(0, 0);
    check("flush1_count", 32'(count), 0);
    step;
    check("flush1_no44", 32'(de_valid), 0);
    flush = 1;
    step;
    flush = 0;
    check("flush_empty", 32'(count), 0);
    de_ready = 0;
    offer(1, 32'hFFFF_FFFC);
    step;
    check("wrap_plus4", de_pc_plus4, 0);
    de_ready = 1;
    offer(1, 32'h500);
    step;
    check("pp_count", 32'(count), 1);
    check("pp_pc", de_pc, 32'h500);
    rst = 1;
    flush = 1;
    step;
    rst = 0;
    flush = 0;
    offer(0, 0);
    check("rf_count", 32'(count), 0);
    check("rf_valid", 32'(de_valid), 0);
    check("rf_inst", de_inst, 32'h13);
    check("rf_pc", de_pc, 0);
    check("rf_ready", 32'(fe_ready), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
